// File: rtl/eeg_link_pkg.sv
// Shared types and sizing helpers for the EEG chip host link.
// The TX state encoding and the RX FIFO entry layout live here.
package eeg_link_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic int beats_of(input int word_dw, input int beat_dw);
        return word_dw / beat_dw;
    endfunction

    // A single-beat word still keeps a one-bit counter so the logic stays uniform.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    // RX entries carry the lst flag above the data bits.
    function automatic int rx_entry_w(input int out_dw);
        return out_dw + 1;
    endfunction

endpackage

// File: rtl/eeg_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and no fall-through:
// a word written into an empty FIFO shows at the head on the following cycle.
module eeg_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    // A push at full is refused even when a pop happens in the same cycle.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = wr_en && !full;
    assign pop    = rd_en && !empty;
    assign rd_dat = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_dat;
    end

endmodule

// File: rtl/eeg_host_link.sv
// Host end of the EEG chip pad protocol: serialises host words into chip beats
// MSB-first and buffers chip result beats for the host, with frame counters.
module eeg_host_link
    import eeg_link_pkg::*;
#(
    parameter int CHIP_DAT_DW = 8,
    parameter int CHIP_OUT_DW = 8,
    parameter int TX_WORD_DW  = 32,
    parameter int RX_DEPTH    = 16,
    parameter int CNT_DW      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   HOST_TX_VLD,
    output logic                   HOST_TX_RDY,
    input  logic [TX_WORD_DW-1:0]  HOST_TX_DAT,
    input  logic                   HOST_TX_CMD,
    input  logic                   HOST_TX_LST,
    output logic                   CHIP_DAT_VLD,
    output logic                   CHIP_DAT_LST,
    input  logic                   CHIP_DAT_RDY,
    output logic [CHIP_DAT_DW-1:0] CHIP_DAT_DAT,
    output logic                   CHIP_DAT_CMD,
    input  logic                   CHIP_OUT_VLD,
    input  logic                   CHIP_OUT_LST,
    output logic                   CHIP_OUT_RDY,
    input  logic [CHIP_OUT_DW-1:0] CHIP_OUT_DAT,
    output logic                   HOST_RX_VLD,
    input  logic                   HOST_RX_RDY,
    output logic [CHIP_OUT_DW-1:0] HOST_RX_DAT,
    output logic                   HOST_RX_LST,
    output logic [CNT_DW-1:0]      TX_FRM_CNT,
    output logic [CNT_DW-1:0]      RX_FRM_CNT
);

    localparam int BEATS = beats_of(TX_WORD_DW, CHIP_DAT_DW);
    localparam int BCW   = beat_cnt_w(BEATS);
    localparam int RXW   = rx_entry_w(CHIP_OUT_DW);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [TX_WORD_DW-1:0] shreg_q;
    logic [BCW-1:0]        beat_cnt_q;
    logic                  cmd_q;
    logic                  lst_q;
    logic                  dat_lst_q;
    logic                  load;
    logic                  shift;
    logic                  beat_accept;
    logic                  is_last;
    logic [CNT_DW-1:0]     tx_frm_q;
    logic [CNT_DW-1:0]     rx_frm_q;

    assign beat_accept = (state_q == SEND) && CHIP_DAT_RDY;
    assign is_last     = (beat_cnt_q == LAST_BEAT);

    // Ready is combinational on CHIP_DAT_RDY at the last beat so words stream without a bubble.
    always_comb begin
        state_d     = state_q;
        HOST_TX_RDY = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (state_q)
            IDLE: begin
                HOST_TX_RDY = 1'b1;
                if (HOST_TX_VLD) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (CHIP_DAT_RDY) begin
                    if (is_last) begin
                        HOST_TX_RDY = 1'b1;
                        if (HOST_TX_VLD) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            beat_cnt_q <= '0;
            cmd_q      <= 1'b0;
            lst_q      <= 1'b0;
            dat_lst_q  <= 1'b0;
            tx_frm_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                shreg_q    <= HOST_TX_DAT;
                beat_cnt_q <= '0;
                cmd_q      <= HOST_TX_CMD;
                lst_q      <= HOST_TX_LST;
                dat_lst_q  <= HOST_TX_LST && (BEATS == 1);
            end else if (shift) begin
                shreg_q    <= shreg_q << CHIP_DAT_DW;
                beat_cnt_q <= beat_cnt_q + BCW'(1);
                dat_lst_q  <= lst_q && ((beat_cnt_q + BCW'(1)) == LAST_BEAT);
            end
            if (beat_accept && dat_lst_q) tx_frm_q <= tx_frm_q + CNT_DW'(1);
        end
    end

    assign CHIP_DAT_VLD = (state_q == SEND);
    assign CHIP_DAT_DAT = shreg_q[TX_WORD_DW-1 -: CHIP_DAT_DW];
    assign CHIP_DAT_CMD = cmd_q;
    assign CHIP_DAT_LST = dat_lst_q;
    assign TX_FRM_CNT   = tx_frm_q;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_wr;
    logic           fifo_rd;
    logic [RXW-1:0] fifo_head;

    // Ready is held low while reset is asserted so nothing is offered to an aborting FIFO.
    assign CHIP_OUT_RDY = rst_n && !fifo_full;
    assign fifo_wr      = CHIP_OUT_VLD && CHIP_OUT_RDY;
    assign HOST_RX_VLD  = !fifo_empty;
    assign fifo_rd      = HOST_RX_VLD && HOST_RX_RDY;
    assign HOST_RX_DAT  = fifo_empty ? '0 : fifo_head[CHIP_OUT_DW-1:0];
    assign HOST_RX_LST  = !fifo_empty && fifo_head[CHIP_OUT_DW];

    eeg_sync_fifo #(
        .WIDTH (RXW),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (fifo_wr),
        .wr_dat ({CHIP_OUT_LST, CHIP_OUT_DAT}),
        .rd_en  (fifo_rd),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_frm_q <= '0;
        end else if (fifo_wr && CHIP_OUT_LST) begin
            rx_frm_q <= rx_frm_q + CNT_DW'(1);
        end
    end

    assign RX_FRM_CNT = rx_frm_q;

endmodule

// File: tb/tb_eeg_host_link.sv
// Directed bench for eeg_host_link with queue scoreboards for the TX beats and RX FIFO.
module tb_eeg_host_link;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        HOST_TX_VLD, HOST_TX_RDY, HOST_TX_CMD, HOST_TX_LST;
    logic [31:0] HOST_TX_DAT;
    logic        CHIP_DAT_VLD, CHIP_DAT_LST, CHIP_DAT_RDY, CHIP_DAT_CMD;
    logic [7:0]  CHIP_DAT_DAT;
    logic        CHIP_OUT_VLD, CHIP_OUT_LST, CHIP_OUT_RDY;
    logic [7:0]  CHIP_OUT_DAT;
    logic        HOST_RX_VLD, HOST_RX_RDY, HOST_RX_LST;
    logic [7:0]  HOST_RX_DAT;
    logic [15:0] TX_FRM_CNT, RX_FRM_CNT;

    eeg_host_link #(
        .CHIP_DAT_DW (8),
        .CHIP_OUT_DW (8),
        .TX_WORD_DW  (32),
        .RX_DEPTH    (DEPTH),
        .CNT_DW      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .HOST_TX_VLD  (HOST_TX_VLD),
        .HOST_TX_RDY  (HOST_TX_RDY),
        .HOST_TX_DAT  (HOST_TX_DAT),
        .HOST_TX_CMD  (HOST_TX_CMD),
        .HOST_TX_LST  (HOST_TX_LST),
        .CHIP_DAT_VLD (CHIP_DAT_VLD),
        .CHIP_DAT_LST (CHIP_DAT_LST),
        .CHIP_DAT_RDY (CHIP_DAT_RDY),
        .CHIP_DAT_DAT (CHIP_DAT_DAT),
        .CHIP_DAT_CMD (CHIP_DAT_CMD),
        .CHIP_OUT_VLD (CHIP_OUT_VLD),
        .CHIP_OUT_LST (CHIP_OUT_LST),
        .CHIP_OUT_RDY (CHIP_OUT_RDY),
        .CHIP_OUT_DAT (CHIP_OUT_DAT),
        .HOST_RX_VLD  (HOST_RX_VLD),
        .HOST_RX_RDY  (HOST_RX_RDY),
        .HOST_RX_DAT  (HOST_RX_DAT),
        .HOST_RX_LST  (HOST_RX_LST),
        .TX_FRM_CNT   (TX_FRM_CNT),
        .RX_FRM_CNT   (RX_FRM_CNT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cmd;
        logic       lst;
        logic [7:0] dat;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    beat_t       tx_q[$];
    logic [8:0]  rx_q[$];
    int          m_cnt = 0;
    int          m_tx_frm = 0;
    int          m_rx_frm = 0;
    int          tx_beats = 0;
    bit          hold_pend = 1'b0;
    logic [9:0]  held;
    beat_t       e;
    bit          wr, rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: model state describes the DUT after the previous rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("tx_frm_cnt", 32'(TX_FRM_CNT), 32'(m_tx_frm));
            check("rx_frm_cnt", 32'(RX_FRM_CNT), 32'(m_rx_frm));
            check("chip_out_rdy", 32'(CHIP_OUT_RDY), 32'(rst_n && (m_cnt < DEPTH)));
            check("host_rx_vld", 32'(HOST_RX_VLD), 32'(m_cnt != 0));
            if (hold_pend)
                check("tx_hold", 32'({CHIP_DAT_VLD, CHIP_DAT_CMD, CHIP_DAT_LST, CHIP_DAT_DAT}),
                      32'({1'b1, held}));
            if (CHIP_DAT_VLD && CHIP_DAT_RDY) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_beat", 32'({CHIP_DAT_CMD, CHIP_DAT_LST, CHIP_DAT_DAT}), 32'h1000);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_beat", 32'({CHIP_DAT_CMD, CHIP_DAT_LST, CHIP_DAT_DAT}), 32'(e));
                    if (e.lst) m_tx_frm++;
                end
                tx_beats++;
            end
            hold_pend = CHIP_DAT_VLD && !CHIP_DAT_RDY;
            held      = {CHIP_DAT_CMD, CHIP_DAT_LST, CHIP_DAT_DAT};
            wr = CHIP_OUT_VLD && (m_cnt < DEPTH);
            rd = HOST_RX_RDY && (m_cnt > 0);
            if (rd) check("rx_pop", 32'({HOST_RX_LST, HOST_RX_DAT}), 32'(rx_q.pop_front()));
            if (wr) begin
                rx_q.push_back({CHIP_OUT_LST, CHIP_OUT_DAT});
                if (CHIP_OUT_LST) m_rx_frm++;
            end
            m_cnt = m_cnt + int'(wr) - int'(rd);
            if (!rst_n) begin
                tx_q.delete();
                rx_q.delete();
                m_cnt     = 0;
                m_tx_frm  = 0;
                m_rx_frm  = 0;
                hold_pend = 1'b0;
            end
        end
    end

    // Presents one word from just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic c, input logic l, output int waits);
        bit ok = 1'b0;
        HOST_TX_DAT = d;
        HOST_TX_CMD = c;
        HOST_TX_LST = l;
        HOST_TX_VLD = 1'b1;
        waits = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            waits++;
            if (HOST_TX_RDY) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx_accept", 32'(ok), 32'd1);
        for (int b = 0; b < 4; b++)
            tx_q.push_back({c, l && (b == 3), d[31-8*b -: 8]});
        @(posedge clk);
        #1;
    endtask

    int w;
    int b0;
    int n;

    initial begin
        rst_n = 1'b0;
        HOST_TX_VLD = 1'b0; HOST_TX_DAT = '0; HOST_TX_CMD = 1'b0; HOST_TX_LST = 1'b0;
        CHIP_DAT_RDY = 1'b0;
        CHIP_OUT_VLD = 1'b0; CHIP_OUT_LST = 1'b0; CHIP_OUT_DAT = '0;
        HOST_RX_RDY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_chip_dat_vld", 32'(CHIP_DAT_VLD), 32'd0);
        check("rst_chip_dat_dat", 32'(CHIP_DAT_DAT), 32'd0);
        check("rst_chip_dat_lst", 32'(CHIP_DAT_LST), 32'd0);
        check("rst_chip_dat_cmd", 32'(CHIP_DAT_CMD), 32'd0);
        check("rst_host_tx_rdy", 32'(HOST_TX_RDY), 32'd1);
        check("rst_host_rx_vld", 32'(HOST_RX_VLD), 32'd0);
        check("rst_host_rx_dat", 32'({HOST_RX_LST, HOST_RX_DAT}), 32'd0);
        check("rst_chip_out_rdy", 32'(CHIP_OUT_RDY), 32'd0);
        check("rst_tx_frm", 32'(TX_FRM_CNT), 32'd0);
        check("rst_rx_frm", 32'(RX_FRM_CNT), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        CHIP_DAT_RDY = 1'b1;

        // Single command word, chip always ready.
        send_word(32'hA1B2C3D4, 1'b1, 1'b1, w);
        HOST_TX_VLD = 1'b0;
        b0 = tx_beats;
        repeat (4) @(posedge clk);
        #1;
        check("t1_beats_in_4_cycles", 32'(tx_beats - b0), 32'd4);
        check("t1_idle_after", 32'(CHIP_DAT_VLD), 32'd0);
        check("t1_tx_frm", 32'(TX_FRM_CNT), 32'd1);

        // Two words back to back with VLD held.
        send_word(32'h01234567, 1'b0, 1'b0, w);
        b0 = tx_beats;
        send_word(32'h89ABCDEF, 1'b1, 1'b1, w);
        check("t2_rdy_on_beat4", 32'(w), 32'd4);
        HOST_TX_VLD = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t2_beats_no_gap", 32'(tx_beats - b0), 32'd8);
        check("t2_tx_frm", 32'(TX_FRM_CNT), 32'd2);

        // Chip ready toggling; beats must hold until accepted.
        b0 = tx_beats;
        fork
            begin
                send_word(32'h5A6B7C8D, 1'b0, 1'b1, w);
                HOST_TX_VLD = 1'b0;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    CHIP_DAT_RDY = (i % 2 == 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        CHIP_DAT_RDY = 1'b1;
        @(posedge clk);
        #1;
        check("t3_beats", 32'(tx_beats - b0), 32'd4);
        check("t3_idle_after", 32'(CHIP_DAT_VLD), 32'd0);
        check("t3_tx_frm", 32'(TX_FRM_CNT), 32'd3);

        // RX overfill with the host stalled, push at full with pop, then drain.
        HOST_RX_RDY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            CHIP_OUT_VLD = 1'b1;
            CHIP_OUT_DAT = 8'(8'h30 + i);
            CHIP_OUT_LST = (i == 7);
            @(posedge clk);
            #1;
            if (i == 15) check("t4_full_rdy_low", 32'(CHIP_OUT_RDY), 32'd0);
        end
        CHIP_OUT_DAT = 8'hEE;
        CHIP_OUT_LST = 1'b0;
        HOST_RX_RDY  = 1'b1;
        @(posedge clk);
        #1;
        CHIP_OUT_VLD = 1'b0;
        check("t4_pop_at_full_rdy", 32'(CHIP_OUT_RDY), 32'd1);
        check("t4_head_after_pop", 32'(HOST_RX_DAT), 32'h31);
        repeat (15) @(posedge clk);
        #1;
        HOST_RX_RDY = 1'b0;
        check("t4_drained", 32'(HOST_RX_VLD), 32'd0);
        check("t4_rdy_back", 32'(CHIP_OUT_RDY), 32'd1);
        check("t4_rx_frm", 32'(RX_FRM_CNT), 32'd1);

        // Reset during the second beat of a word, with one RX entry held.
        CHIP_OUT_VLD = 1'b1;
        CHIP_OUT_DAT = 8'h77;
        CHIP_OUT_LST = 1'b1;
        send_word(32'hCAFEF00D, 1'b1, 1'b1, w);
        CHIP_OUT_VLD = 1'b0;
        HOST_TX_VLD  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_chip_dat_vld", 32'(CHIP_DAT_VLD), 32'd0);
        check("t6_host_rx_vld", 32'(HOST_RX_VLD), 32'd0);
        check("t6_tx_frm", 32'(TX_FRM_CNT), 32'd0);
        check("t6_rx_frm", 32'(RX_FRM_CNT), 32'd0);
        check("t6_host_tx_rdy", 32'(HOST_TX_RDY), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_word_aborted", 32'(CHIP_DAT_VLD), 32'd0);

        // Steady push and pop at occupancy 5.
        HOST_RX_RDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            CHIP_OUT_VLD = 1'b1;
            CHIP_OUT_DAT = 8'(8'h40 + i);
            CHIP_OUT_LST = 1'b0;
            @(posedge clk);
            #1;
        end
        HOST_RX_RDY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            CHIP_OUT_DAT = 8'(8'h50 + i);
            CHIP_OUT_LST = (i == 2);
            @(posedge clk);
            #1;
        end
        CHIP_OUT_VLD = 1'b0;
        CHIP_OUT_LST = 1'b0;
        check("t5_rx_frm", 32'(RX_FRM_CNT), 32'd1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!HOST_RX_VLD) break;
            n++;
        end
        check("t5_count_held", 32'(n), 32'd5);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
